ctrl_fsm: RTL and testbench

Parametrised multi-cycle control unit for the cpu_v0 datapath, successor to the single-cycle controller. Sits between the instruction memory/IO front end and the datapath (PC, register file, RAM, ALU). It adds an explicit fetch/execute state machine, a start/done handshake for multi-cycle ALU ops (MUL, DIV), one-cycle write-strobe semantics, and an interrupt-driven IO mode with acknowledge.

---
 rtl/ctrl_fsm_pkg.sv | 55 +++++
 rtl/ctrl_fsm_if.sv | 48 ++++
 rtl/ctrl_fsm_decode.sv | 102 ++++++++++
 rtl/ctrl_fsm.sv | 163 ++++++++++++++++
 tb/tb_ctrl_fsm.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_fsm_pkg.sv
// Shared definitions for the multi-cycle controller: opcodes, rd-source
// selects, FSM state encoding and the decoded control word.
package ctrl_fsm_pkg;

   typedef enum logic [2:0] {
      ST_FETCH    = 3'd0,
      ST_EXEC     = 3'd1,
      ST_WAIT     = 3'd2,
      ST_WB       = 3'd3,
      ST_IO_FETCH = 3'd4,
      ST_IO_EXEC  = 3'd5,
      ST_IO_HOLD  = 3'd6
   } state_t;

   localparam logic [3:0] OP_LOAD  = 4'h0;
   localparam logic [3:0] OP_STORE = 4'h1;
   localparam logic [3:0] OP_MOVE  = 4'h2;
   localparam logic [3:0] OP_JUMP  = 4'h3;
   localparam logic [3:0] OP_MUL   = 4'hE;
   localparam logic [3:0] OP_DIV   = 4'hF;

   localparam logic [3:0] IO_LD_REG  = 4'h0;
   localparam logic [3:0] IO_LD_RAM  = 4'h1;
   localparam logic [3:0] IO_LD_INS  = 4'h2;
   localparam logic [3:0] IO_OUT_REG = 4'h3;
   localparam logic [3:0] IO_OUT_RAM = 4'h4;

   localparam logic [1:0] SEL_RAM = 2'd0;
   localparam logic [1:0] SEL_ALU = 2'd1;
   localparam logic [1:0] SEL_IO  = 2'd2;

   typedef struct packed {
      logic en_offset;
      logic en_cnt;
      logic ram_we;
      logic rd_we;
      logic en_mv;
      logic ins_we;
      logic alu_start;
      logic io_ack;
   } strobe_t;

   typedef struct packed {
      strobe_t    stb;
      logic [3:0] alu_op;
      logic [1:0] rd_sel;
      logic       mux_ram_rs0_io;
      logic       mux_io_rs0_ram;
   } ctrl_word_t;

   function automatic logic is_multi(input logic [3:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/ctrl_fsm_if.sv
// Controller <-> front end / datapath bundle. master = controller side.
interface ctrl_fsm_if #(
   parameter int INST_W = 16,
   parameter int REG_AW = 4,
   parameter int RAM_AW = 8,
   parameter int INS_AW = 4
) ();
   logic              interrupt;
   logic              inst_valid;
   logic [INST_W-1:0] instruction;
   logic              alu_done;
   logic              inst_ready;
   logic [3:0]        alu_op;
   logic              alu_start;
   logic [INS_AW-1:0] pc_offset;
   logic [INS_AW-1:0] addr_ins;
   logic [RAM_AW-1:0] addr_ram;
   logic [REG_AW-1:0] addr_rs0;
   logic [REG_AW-1:0] addr_rs1;
   logic [REG_AW-1:0] addr_rd;
   logic              en_offset;
   logic              en_cnt;
   logic              ram_we;
   logic              rd_we;
   logic              en_mv;
   logic              ins_we;
   logic              mux_ram_rs0_io;
   logic              mux_io_rs0_ram;
   logic [1:0]        mux_rd_sel;
   logic              io_ack;
   logic              busy;

   modport master (
      input  interrupt, inst_valid, instruction, alu_done,
      output inst_ready, alu_op, alu_start, pc_offset, addr_ins, addr_ram,
             addr_rs0, addr_rs1, addr_rd, en_offset, en_cnt, ram_we, rd_we,
             en_mv, ins_we, mux_ram_rs0_io, mux_io_rs0_ram, mux_rd_sel,
             io_ack, busy
   );

   modport slave (
      output interrupt, inst_valid, instruction, alu_done,
      input  inst_ready, alu_op, alu_start, pc_offset, addr_ins, addr_ram,
             addr_rs0, addr_rs1, addr_rd, en_offset, en_cnt, ram_we, rd_we,
             en_mv, ins_we, mux_ram_rs0_io, mux_io_rs0_ram, mux_rd_sel,
             io_ack, busy
   );
endinterface

// File: rtl/ctrl_fsm_decode.sv
// Combinational opcode -> control word decode, shared by EXEC and IO_EXEC.
// Address fields are cast to the port width (zero-extend or truncate).
module ctrl_decode
   import ctrl_fsm_pkg::*;
#(
   parameter int INST_W = 16,
   parameter int REG_AW = 4,
   parameter int RAM_AW = 8,
   parameter int INS_AW = 4
) (
   input  logic [INST_W-1:0] i_inst,
   input  logic              i_io_mode,
   output ctrl_word_t        o_cw,
   output logic [INS_AW-1:0] o_pc_offset,
   output logic [INS_AW-1:0] o_addr_ins,
   output logic [RAM_AW-1:0] o_addr_ram,
   output logic [REG_AW-1:0] o_addr_rs0,
   output logic [REG_AW-1:0] o_addr_rs1,
   output logic [REG_AW-1:0] o_addr_rd
);
   logic [3:0] w_op;
   assign w_op = i_inst[INST_W-1 -: 4];

   // Control word for the current opcode; unused fields default to zero.
   always_comb begin
      o_cw        = '0;
      o_pc_offset = '0;
      o_addr_ins  = '0;
      o_addr_ram  = '0;
      o_addr_rs0  = '0;
      o_addr_rs1  = '0;
      o_addr_rd   = '0;
      if (i_io_mode) begin
         o_cw.mux_ram_rs0_io = 1'b1;
         o_cw.rd_sel         = SEL_IO;
         o_cw.alu_op         = 4'h0;
         o_cw.stb.io_ack     = 1'b1;
         case (w_op)
            IO_LD_REG: begin
               o_addr_rd      = REG_AW'(i_inst[11:8]);
               o_cw.stb.rd_we = 1'b1;
            end
            IO_LD_RAM: begin
               o_addr_ram      = RAM_AW'(i_inst[11:4]);
               o_cw.stb.ram_we = 1'b1;
            end
            IO_LD_INS: begin
               o_addr_ins      = INS_AW'(i_inst[11:8]);
               o_cw.stb.ins_we = 1'b1;
            end
            IO_OUT_REG: o_addr_rs0 = REG_AW'(i_inst[11:8]);
            IO_OUT_RAM: begin
               o_addr_ram          = RAM_AW'(i_inst[11:4]);
               o_cw.mux_io_rs0_ram = 1'b1;
            end
            default: o_cw.stb.io_ack = 1'b1;
         endcase
      end else begin
         o_cw.alu_op = w_op;
         case (w_op)
            OP_LOAD: begin
               o_addr_ram      = RAM_AW'(i_inst[7:0]);
               o_addr_rd       = REG_AW'(i_inst[11:8]);
               o_cw.stb.rd_we  = 1'b1;
               o_cw.stb.en_cnt = 1'b1;
               o_cw.rd_sel     = SEL_RAM;
            end
            OP_STORE: begin
               o_addr_ram      = RAM_AW'(i_inst[11:4]);
               o_addr_rs0      = REG_AW'(i_inst[3:0]);
               o_cw.stb.ram_we = 1'b1;
               o_cw.stb.en_cnt = 1'b1;
            end
            OP_MOVE: begin
               o_addr_rs0      = REG_AW'(i_inst[3:0]);
               o_addr_rd       = i_inst[REG_AW+3:4];
               o_cw.stb.en_mv  = 1'b1;
               o_cw.stb.en_cnt = 1'b1;
            end
            OP_JUMP: begin
               o_pc_offset        = INS_AW'(i_inst[11:8]);
               o_cw.stb.en_offset = 1'b1;
            end
            OP_MUL, OP_DIV: begin
               o_addr_rs0         = REG_AW'(i_inst[7:4]);
               o_addr_rs1         = REG_AW'(i_inst[3:0]);
               o_addr_rd          = REG_AW'(i_inst[11:8]);
               o_cw.stb.alu_start = 1'b1;
               o_cw.rd_sel        = SEL_ALU;
            end
            default: begin
               o_addr_rs0      = REG_AW'(i_inst[7:4]);
               o_addr_rs1      = REG_AW'(i_inst[3:0]);
               o_addr_rd       = REG_AW'(i_inst[11:8]);
               o_cw.stb.rd_we  = 1'b1;
               o_cw.stb.en_cnt = 1'b1;
               o_cw.rd_sel     = SEL_ALU;
            end
         endcase
      end
   end
endmodule

// File: rtl/ctrl_fsm.sv
// Multi-cycle fetch/execute controller with ALU start/done handshake and
// interrupt-driven IO mode. Every output is driven from a register.
module ctrl_fsm
   import ctrl_fsm_pkg::*;
#(
   parameter int INST_W = 16,
   parameter int REG_AW = 4,
   parameter int RAM_AW = 8,
   parameter int INS_AW = 4
) (
   input logic        clock,
   input logic        reset,
   ctrl_fsm_if.master bus
);
   state_t            r_state, w_next;
   logic [INST_W-1:0] r_ir;
   logic              w_load_ir, w_upd, w_io_mode;
   logic              r_inst_ready, r_busy;
   strobe_t           r_stb, w_stb;
   ctrl_word_t        w_cw;
   logic [3:0]        r_alu_op;
   logic [1:0]        r_rd_sel;
   logic              r_mux_ram_rs0_io, r_mux_io_rs0_ram;
   logic [INS_AW-1:0] w_pc_offset, w_addr_ins, r_pc_offset, r_addr_ins;
   logic [RAM_AW-1:0] w_addr_ram, r_addr_ram;
   logic [REG_AW-1:0] w_addr_rs0, w_addr_rs1, w_addr_rd;
   logic [REG_AW-1:0] r_addr_rs0, r_addr_rs1, r_addr_rd;

   assign w_io_mode = (r_state == ST_IO_EXEC);
   assign w_upd     = (r_state == ST_EXEC) || (r_state == ST_IO_EXEC);

   ctrl_decode #(
      .INST_W(INST_W), .REG_AW(REG_AW), .RAM_AW(RAM_AW), .INS_AW(INS_AW)
   ) u_decode (
      .i_inst     (r_ir),
      .i_io_mode  (w_io_mode),
      .o_cw       (w_cw),
      .o_pc_offset(w_pc_offset),
      .o_addr_ins (w_addr_ins),
      .o_addr_ram (w_addr_ram),
      .o_addr_rs0 (w_addr_rs0),
      .o_addr_rs1 (w_addr_rs1),
      .o_addr_rd  (w_addr_rd)
   );

   // Next state and next-cycle strobes. alu_done coinciding with the
   // visible alu_start pulse is ignored.
   always_comb begin
      w_next    = r_state;
      w_load_ir = 1'b0;
      w_stb     = '0;
      case (r_state)
         ST_FETCH: begin
            if (bus.interrupt) begin
               w_next = ST_IO_FETCH;
            end else if (bus.inst_valid && r_inst_ready) begin
               w_load_ir = 1'b1;
               w_next    = ST_EXEC;
            end else begin
               w_next = ST_FETCH;
            end
         end
         ST_EXEC: begin
            w_stb  = w_cw.stb;
            w_next = is_multi(r_ir[INST_W-1 -: 4]) ? ST_WAIT : ST_FETCH;
         end
         ST_WAIT: begin
            if (bus.alu_done && !r_stb.alu_start) begin
               w_stb.rd_we  = 1'b1;
               w_stb.en_cnt = 1'b1;
               w_next       = ST_WB;
            end else begin
               w_next = ST_WAIT;
            end
         end
         ST_WB: w_next = ST_FETCH;
         ST_IO_FETCH: begin
            if (!bus.interrupt) begin
               w_next = ST_FETCH;
            end else if (bus.inst_valid && r_inst_ready) begin
               w_load_ir = 1'b1;
               w_next    = ST_IO_EXEC;
            end else begin
               w_next = ST_IO_FETCH;
            end
         end
         ST_IO_EXEC: begin
            w_stb  = w_cw.stb;
            w_next = ST_IO_HOLD;
         end
         ST_IO_HOLD: begin
            if (!bus.interrupt) begin
               w_next = ST_FETCH;
            end else begin
               w_next = ST_IO_HOLD;
            end
         end
         default: w_next = ST_FETCH;
      endcase
   end

   // State, instruction register and all output registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state          <= ST_FETCH;
         r_ir             <= '0;
         r_inst_ready     <= 1'b0;
         r_busy           <= 1'b0;
         r_stb            <= '0;
         r_alu_op         <= 4'h0;
         r_rd_sel         <= 2'd0;
         r_mux_ram_rs0_io <= 1'b0;
         r_mux_io_rs0_ram <= 1'b0;
         r_pc_offset      <= '0;
         r_addr_ins       <= '0;
         r_addr_ram       <= '0;
         r_addr_rs0       <= '0;
         r_addr_rs1       <= '0;
         r_addr_rd        <= '0;
      end else begin
         r_state      <= w_next;
         r_inst_ready <= (w_next == ST_FETCH) || (w_next == ST_IO_FETCH);
         r_busy       <= (w_next != ST_FETCH);
         r_stb        <= w_stb;
         if (w_load_ir) begin
            r_ir <= bus.instruction;
         end
         if (w_upd) begin
            r_alu_op         <= w_cw.alu_op;
            r_rd_sel         <= w_cw.rd_sel;
            r_mux_ram_rs0_io <= w_cw.mux_ram_rs0_io;
            r_mux_io_rs0_ram <= w_cw.mux_io_rs0_ram;
            r_pc_offset      <= w_pc_offset;
            r_addr_ins       <= w_addr_ins;
            r_addr_ram       <= w_addr_ram;
            r_addr_rs0       <= w_addr_rs0;
            r_addr_rs1       <= w_addr_rs1;
            r_addr_rd        <= w_addr_rd;
         end
      end
   end

   assign bus.inst_ready     = r_inst_ready;
   assign bus.busy           = r_busy;
   assign bus.alu_op         = r_alu_op;
   assign bus.alu_start      = r_stb.alu_start;
   assign bus.pc_offset      = r_pc_offset;
   assign bus.addr_ins       = r_addr_ins;
   assign bus.addr_ram       = r_addr_ram;
   assign bus.addr_rs0       = r_addr_rs0;
   assign bus.addr_rs1       = r_addr_rs1;
   assign bus.addr_rd        = r_addr_rd;
   assign bus.en_offset      = r_stb.en_offset;
   assign bus.en_cnt         = r_stb.en_cnt;
   assign bus.ram_we         = r_stb.ram_we;
   assign bus.rd_we          = r_stb.rd_we;
   assign bus.en_mv          = r_stb.en_mv;
   assign bus.ins_we         = r_stb.ins_we;
   assign bus.mux_ram_rs0_io = r_mux_ram_rs0_io;
   assign bus.mux_io_rs0_ram = r_mux_io_rs0_ram;
   assign bus.mux_rd_sel     = r_rd_sel;
   assign bus.io_ack         = r_stb.io_ack;
endmodule

// File: tb/tb_ctrl_fsm.sv
// Scoreboard bench for ctrl_fsm: the driver queues the expected control word
// and cycle of every strobe; the monitor pops on each strobe it observes.
module tb_ctrl_fsm;
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   ctrl_fsm_if bus ();
   ctrl_fsm dut (.clock(clock), .reset(reset), .bus(bus));

   localparam logic [7:0] S_OFF = 8'h80, S_CNT = 8'h40, S_RAMWE = 8'h20, S_RDWE = 8'h10;
   localparam logic [7:0] S_MV = 8'h08, S_INSWE = 8'h04, S_START = 8'h02, S_ACK = 8'h01;

   typedef struct {
      string       nm;
      int          cy;
      logic [43:0] val;
      logic [43:0] msk;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   int   a;

   always @(posedge clock) cyc <= cyc + 1;

   // {strobes[8], alu_op, rd_sel, mux_ram_rs0_io, mux_io_rs0_ram, pc_offset, addr_ins, addr_ram, rs0, rs1, rd}
   function automatic logic [43:0] snap();
      return {bus.en_offset, bus.en_cnt, bus.ram_we, bus.rd_we, bus.en_mv, bus.ins_we,
              bus.alu_start, bus.io_ack, bus.alu_op, bus.mux_rd_sel, bus.mux_ram_rs0_io,
              bus.mux_io_rs0_ram, bus.pc_offset, bus.addr_ins, bus.addr_ram,
              bus.addr_rs0, bus.addr_rs1, bus.addr_rd};
   endfunction

   function automatic void put(inout logic [43:0] v, inout logic [43:0] m,
                               input int lsb, input int w, input int x);
      if (x >= 0)
         for (int i = 0; i < w; i++) begin
            v[lsb+i] = x[i];
            m[lsb+i] = 1'b1;
         end
   endfunction

   // A field value of -1 means "not constrained for this event".
   task automatic sb_push(input string nm, input int cy, input logic [7:0] stb, input int op,
                          input int sel, input int mra, input int mir, input int pco,
                          input int ains, input int aram, input int rs0, input int rs1,
                          input int rd);
      exp_t e;
      logic [43:0] v, m;
      v = 44'h0;
      m = 44'h0;
      put(v, m, 36, 8, int'(stb));
      put(v, m, 32, 4, op);
      put(v, m, 30, 2, sel);
      put(v, m, 29, 1, mra);
      put(v, m, 28, 1, mir);
      put(v, m, 24, 4, pco);
      put(v, m, 20, 4, ains);
      put(v, m, 12, 8, aram);
      put(v, m, 8, 4, rs0);
      put(v, m, 4, 4, rs1);
      put(v, m, 0, 4, rd);
      e.nm  = nm;
      e.cy  = cy;
      e.val = v;
      e.msk = m;
      sb.push_back(e);
   endtask

   task automatic check(input string nm, input logic [43:0] got, input logic [43:0] req);
      n_cmp++;
      if (got !== req) begin
         n_bad++;
         $display("FAIL %s: got %h required %h", nm, got, req);
      end
   endtask

   // Monitor: every cycle with any strobe high must match the queue head.
   always @(negedge clock) begin
      logic [43:0] o;
      exp_t        e;
      if (!reset) begin
         o = snap();
         if (o[43:36] != 8'h00) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_strobe: got %h at cycle %0d required no strobe", o, cyc);
            end else begin
               e = sb.pop_front();
               if ((((o ^ e.val) & e.msk) != 44'h0) || (cyc != e.cy)) begin
                  n_bad++;
                  $display("FAIL %s: got %h at cycle %0d required %h (mask %h) at cycle %0d",
                           e.nm, o, cyc, e.val, e.msk, e.cy);
               end
            end
         end
      end
   end

   task automatic wait_ready(input bit io);
      int k = 0;
      while (!(bus.inst_ready === 1'b1 && bus.busy === io) && k < 50) begin
         @(negedge clock);
         k++;
      end
      if (k >= 50) begin
         n_cmp++;
         n_bad++;
         $display("FAIL ready_timeout: got inst_ready=%b busy=%b required 1/%b", bus.inst_ready, bus.busy, io);
      end
   endtask

   // Returns the cycle count seen at the negedge right after the accept edge.
   task automatic send(input logic [15:0] w, input bit io, output int acc);
      wait_ready(io);
      bus.instruction = w;
      bus.inst_valid  = 1'b1;
      @(negedge clock);
      acc             = cyc;
      bus.inst_valid  = 1'b0;
      bus.instruction = 16'h0;
   endtask

   task automatic io_cmd(input logic [15:0] w, input string nm, input logic [7:0] stb,
                         input int mir, input int ains, input int aram);
      int acc;
      bus.interrupt = 1'b1;
      send(w, 1'b1, acc);
      sb_push(nm, acc + 1, stb, 0, 2, 1, mir, -1, ains, aram, -1, -1, -1);
      @(negedge clock);
      bus.interrupt = 1'b0;
      repeat (2) @(negedge clock);
   endtask

   initial begin
      bus.interrupt   = 1'b0;
      bus.inst_valid  = 1'b0;
      bus.instruction = 16'h0;
      bus.alu_done    = 1'b0;
      repeat (2) @(negedge clock);
      check("reset_outputs", snap(), 44'h0);
      check("reset_busy_ready", {42'b0, bus.busy, bus.inst_ready}, 44'h0);
      reset = 1'b0;
      @(negedge clock);
      check("ready_after_reset", {42'b0, bus.busy, bus.inst_ready}, 44'h1);

      send(16'hC321, 1'b0, a); sb_push("add", a + 1, S_RDWE | S_CNT, 12, 1, -1, -1, -1, -1, -1, 2, 1, 3);
      send(16'h0A5C, 1'b0, a); sb_push("load", a + 1, S_RDWE | S_CNT, -1, 0, -1, -1, -1, -1, 8'h5C, -1, -1, 10);
      send(16'h1AB7, 1'b0, a); sb_push("store", a + 1, S_RAMWE | S_CNT, -1, -1, -1, -1, -1, -1, 8'hAB, 7, -1, -1);
      send(16'h2039, 1'b0, a); sb_push("move", a + 1, S_MV | S_CNT, -1, -1, -1, -1, -1, -1, -1, 9, -1, 3);
      send(16'h3700, 1'b0, a); sb_push("jump", a + 1, S_OFF, -1, -1, -1, -1, 7, -1, -1, -1, -1, -1);

      // MUL: alu_done three cycles after the alu_start pulse
      send(16'hE456, 1'b0, a); sb_push("mul_start", a + 1, S_START, 14, 1, -1, -1, -1, -1, -1, 5, 6, 4);
      check("mul_busy", {43'b0, bus.busy}, 44'h1);
      repeat (4) begin
         @(negedge clock);
         check("mul_busy", {43'b0, bus.busy}, 44'h1);
      end
      bus.alu_done = 1'b1;
      sb_push("mul_wb", cyc + 1, S_RDWE | S_CNT, 14, 1, -1, -1, -1, -1, -1, 5, 6, 4);
      @(negedge clock);
      bus.alu_done = 1'b0;
      check("mul_busy_wb", {43'b0, bus.busy}, 44'h1);
      @(negedge clock);
      check("mul_idle", {42'b0, bus.busy, bus.inst_ready}, 44'h1);

      // DIV: alu_done alongside alu_start is ignored; interrupt raised mid-wait
      send(16'hF123, 1'b0, a); sb_push("div_start", a + 1, S_START, 15, 1, -1, -1, -1, -1, -1, 2, 3, 1);
      @(negedge clock);
      bus.alu_done = 1'b1;
      @(negedge clock);
      bus.alu_done  = 1'b0;
      bus.interrupt = 1'b1;
      @(negedge clock);
      bus.alu_done = 1'b1;
      sb_push("div_wb", cyc + 1, S_RDWE | S_CNT, 15, 1, -1, -1, -1, -1, -1, 2, 3, 1);
      @(negedge clock);
      bus.alu_done = 1'b0;
      send(16'h1AB0, 1'b1, a); sb_push("io_ld_ram", a + 1, S_RAMWE | S_ACK, 0, 2, 1, 0, -1, -1, 8'hAB, -1, -1, -1);
      repeat (4) begin
         @(negedge clock);
         check("io_hold", {42'b0, bus.busy, bus.inst_ready}, 44'h2);
      end
      bus.interrupt = 1'b0;
      @(negedge clock);
      check("io_release", {42'b0, bus.busy, bus.inst_ready}, 44'h1);

      io_cmd(16'h9000, "io_reserved", S_ACK, -1, -1, -1);
      io_cmd(16'h2500, "io_ld_ins", S_INSWE | S_ACK, -1, 5, -1);
      io_cmd(16'h4CD0, "io_out_ram", S_ACK, 1, -1, 8'hCD);

      // Asynchronous reset while waiting on the ALU
      send(16'hE123, 1'b0, a); sb_push("mul2_start", a + 1, S_START, 14, 1, -1, -1, -1, -1, -1, 2, 3, 1);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      #1;
      check("async_reset_outputs", snap(), 44'h0);
      check("async_reset_busy_ready", {42'b0, bus.busy, bus.inst_ready}, 44'h0);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check("fetch_after_reset", {42'b0, bus.busy, bus.inst_ready}, 44'h1);
      bus.alu_done = 1'b1;
      @(negedge clock);
      bus.alu_done = 1'b0;
      repeat (3) @(negedge clock);

      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d pending events required 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: got no finish required finish before 100000");
      $fatal(1, "timeout");
   end
endmodule
